// File: rtl/lz_shift_normalizer_if.sv
`default_nettype none
// ============================================================================
//  Module   : lz_shift_normalizer_if
//  Purpose  : Request/result bundle for the leading-zero shift normalizer.
//             The master drives the request and the slave returns the result.
//             Macro NORM_SHIFT_LIMIT_EN adds the shift-limit input and the
//             limited flag.
//  Revision : 1.0  initial release
// ============================================================================
interface lz_shift_normalizer_if #(
  parameter int SW = 26
);
  logic          start;
  logic [SW-1:0] Data_i;
  logic          busy;
  logic          done;
  logic [SW-1:0] Data_o;
  logic [4:0]    Shift_o;
  logic          Zero_o;
`ifdef NORM_SHIFT_LIMIT_EN
  logic [4:0]    Limit_i;
  logic          Limited_o;
`endif

  modport master (
    output start,
    output Data_i,
    input  busy,
    input  done,
    input  Data_o,
    input  Shift_o,
    input  Zero_o
`ifdef NORM_SHIFT_LIMIT_EN
    , output Limit_i
    , input  Limited_o
`endif
  );

  modport slave (
    input  start,
    input  Data_i,
    output busy,
    output done,
    output Data_o,
    output Shift_o,
    output Zero_o
`ifdef NORM_SHIFT_LIMIT_EN
    , input  Limit_i
    , output Limited_o
`endif
  );
endinterface
`default_nettype wire

// File: rtl/lz_shift_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : lz_shift_normalizer
//  Purpose  : Sequential leading-zero normalizer. Shifts the captured
//             significand left one bit per cycle until its MSB is set and
//             counts the shifts (exponent decrement). Zero input is flagged.
//             Macro NORM_SHIFT_LIMIT_EN adds a shift limit for denormal
//             results, so the exponent cannot underflow.
//  Revision : 1.0  initial release
// ============================================================================
module lz_shift_normalizer #(
  parameter int SW = 26   // legal 2..32; must match the interface SW
) (
  input  logic                  clk,
  input  logic                  rst,
  lz_shift_normalizer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] data_q,  data_d;
  logic [4:0]    shift_q, shift_d;
  logic          zero_q,  zero_d;
`ifdef NORM_SHIFT_LIMIT_EN
  logic [4:0]    limit_q, limit_d;
  logic          limited_q, limited_d;
`endif

  // Next-state and datapath: load on accepted start, then test/shift per cycle
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    shift_d = shift_q;
    zero_d  = zero_q;
`ifdef NORM_SHIFT_LIMIT_EN
    limit_d   = limit_q;
    limited_d = limited_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // Start is accepted in DONE too, giving back-to-back operation
        if (bus.start) begin
          state_d = S_SHIFT;
          data_d  = bus.Data_i;
          shift_d = 5'd0;
          zero_d  = 1'b0;
`ifdef NORM_SHIFT_LIMIT_EN
          limit_d   = bus.Limit_i;
          limited_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (data_q == '0) begin
          zero_d  = 1'b1;
          shift_d = 5'd0;
          state_d = S_DONE;
        end else if (data_q[SW-1]) begin
          state_d = S_DONE;
        end
`ifdef NORM_SHIFT_LIMIT_EN
        else if (shift_q == limit_q) begin
          limited_d = 1'b1;
          state_d   = S_DONE;
        end
`endif
        else begin
          // At most SW-1 shifts occur, so the 5-bit count never wraps
          data_d  = {data_q[SW-2:0], 1'b0};
          shift_d = shift_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      shift_q <= 5'd0;
      zero_q  <= 1'b0;
`ifdef NORM_SHIFT_LIMIT_EN
      limit_q   <= 5'd0;
      limited_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
`ifdef NORM_SHIFT_LIMIT_EN
      limit_q   <= limit_d;
      limited_q <= limited_d;
`endif
    end
  end

  // Status flags decode the registered state only
  assign bus.busy    = (state_q == S_SHIFT);
  assign bus.done    = (state_q == S_DONE);
  assign bus.Data_o  = data_q;
  assign bus.Shift_o = shift_q;
  assign bus.Zero_o  = zero_q;
`ifdef NORM_SHIFT_LIMIT_EN
  assign bus.Limited_o = limited_q;
`endif

endmodule
`default_nettype wire

// File: doc/lz_shift_normalizer.md
# lz_shift_normalizer

- Sequential leading-zero normalizer for the FPU post-operation path.
- Takes an unnormalized significand, shifts it left one bit per cycle until its MSB is 1, and counts the shifts.
- Delivers the normalized significand plus a 5-bit shift count. The count drives the B operand of the exponent subtractor (Y = A − B).
- Sits between the significand adder output and exponent adjustment in both single- and double-precision datapaths.

## Interface
Parameters:
- SW, 26, significand width in bits; legal range 2..32, so that SW−1 fits in 5 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- Data_i  in  SW  unnormalized significand, sampled with start.
- busy  out  1  high while normalizing; start ignored.
- done  out  1  one-cycle pulse; results valid.
- Data_o  out  SW  normalized significand.
- Shift_o  out  5  number of left shifts applied (exponent decrement).
- Zero_o  out  1  input was all zeros.

## Operation
States: IDLE, SHIFT, DONE.

- **IDLE:** busy=0, done=0.
  - On start=1: load Data_o←Data_i, Shift_o←0, Zero_o←0; go to SHIFT.
- **SHIFT:** busy=1. Checks are evaluated in priority order:
  1. Data_o==0: Zero_o←1, Shift_o←0; go to DONE.
  2. Data_o[SW-1]==1: go to DONE; Data_o and Shift_o are held.
  3. Otherwise: Data_o←{Data_o[SW-2:0],1'b0}, Shift_o←Shift_o+1; stay in SHIFT.
- **DONE:** done=1, busy=0. Outputs are held.
  - start=1: reload exactly as from IDLE and go to SHIFT (back-to-back operation).
  - start=0: go to IDLE.
- Data_o, Shift_o and Zero_o hold their last result until the next accepted start.
- Data_o, Shift_o and Zero_o are not valid while busy=1.
- Shift_o never exceeds SW−1, so it cannot wrap.
- start while busy=1 is ignored: no re-load, no error.
- Data_i is captured only at the accepting edge; later changes have no effect.

## Timing
- Reset values:
  - State IDLE; busy=0, done=0.
  - Data_o=0, Shift_o=0, Zero_o=0.
- Call the edge that accepts start edge 0.
- busy is high from edge 0 to edge k+1.
- done is high for exactly one cycle, after edge k+1, where k is the number of leading zeros:
  - nonzero input: k = leading zeros of Data_i.
  - zero input: k=0, so done follows edge 1.
- Worst case: SW cycles from the accepting edge (k=SW−1).
- Throughput: one result per k+2 cycles with back-to-back starts; start is accepted in the DONE cycle.
- rst asserted mid-operation: immediate return to IDLE with all outputs at reset values; the in-flight request is lost and no done is issued.
- busy and done are decoded from registered state; there are no combinational paths from inputs to outputs.

## Configuration
Macro NORM_SHIFT_LIMIT_EN.

- Defined:
  - Adds input Limit_i [4:0], sampled with start, and output Limited_o (1).
  - In SHIFT, a third check is inserted after the MSB check: if Shift_o==Limit_i, set Limited_o←1 and go to DONE without further shifting.
  - This covers denormal results, where the exponent must not underflow.
  - Limited_o resets to 0, clears on each accepted start, and holds with the other outputs.
- Undefined:
  - Ports Limit_i and Limited_o are absent.
  - Shifting stops only on MSB=1 or zero input.

## Test plan
SW=26 throughout.
- Data_i=0x0800000 (bit 23 set), start pulse → Data_o=0x2000000, Shift_o=2, Zero_o=0, done one cycle after edge 3.
- Data_i=0x0000001 → Data_o=0x2000000, Shift_o=25, done after edge 26; busy high for 26 cycles.
- Data_i=0x0000000 → Zero_o=1, Shift_o=0, Data_o=0, done after edge 1. Data_i=0x3FFFFFF → Shift_o=0, Data_o=0x3FFFFFF, done after edge 1.
- Back-to-back:
  - Assert start with Data_i=0x0400000 in the DONE cycle of a previous request → new request accepted; second done shows Shift_o=3.
  - start pulsed while busy → ignored, first result unchanged.
- Reset mid-operation: rst pulsed at edge 5 of a Data_i=0x0000001 run → all outputs 0, state IDLE, no done. A following start with 0x1000000 gives Shift_o=1.
- With NORM_SHIFT_LIMIT_EN: Data_i=0x0000100, Limit_i=4 → Shift_o=4, Data_o=0x0001000, Limited_o=1, done after edge 5.
